conf_pkt_parser: RTL and testbench

CONF_PKT_PARSER -- requirements
Module: conf_pkt_parser

---
 rtl/conf_pkt_parser.sv | 158 +++++++++++++++
 tb/tb_conf_pkt_parser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_pkt_parser.sv
// conf_pkt_parser
//
// Sits on a 134-bit beat stream. Normal packets are forwarded one cycle later
// with their beats bit-identical. Configuration packets, whose head carries
// CONF_ETHERTYPE in bits [31:16], are consumed here. Each of their body and
// tail beats becomes a 32-bit register write. Configuration packets never
// appear on o_data.
//
// Build option:
//   CONF_PKT_STATS_EN  when defined, adds the saturating packet and
//                      framing-error counters. When it is undefined, both
//                      counter outputs read 0 and no counter flops exist.
//
// Ports:
//   i_clk           clock; all logic runs on its rising edge
//   i_rst           synchronous active-high reset
//   i_data_valid    input beat qualifier; there is no backpressure
//   i_data[133:0]   [133:132] position (01 head, 00 body, 10 tail, 11 single)
//                   [131:128] byte info, [127:0] payload
//   o_data_valid    forwarded beat qualifier
//   o_data[133:0]   forwarded beat
//   o_conf_valid    one-cycle configuration write strobe
//   o_conf_addr     write address, taken from payload [47:16]
//   o_conf_data     write data, taken from payload [79:48]
//   o_cnt_conf_pkt  number of complete configuration packets, saturating
//   o_cnt_err       number of framing errors, saturating

module conf_pkt_parser #(
    parameter logic [15:0] CONF_ETHERTYPE = 16'h9006,
    parameter int unsigned FWD_LAT        = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_data_valid,
    input  logic [133:0] i_data,
    output logic         o_data_valid,
    output logic [133:0] o_data,
    output logic         o_conf_valid,
    output logic [31:0]  o_conf_addr,
    output logic [31:0]  o_conf_data,
    output logic [15:0]  o_cnt_conf_pkt,
    output logic [15:0]  o_cnt_err
);

    // Only a single register stage is implemented.
    if (FWD_LAT != 1) begin : g_bad_lat
        $error("conf_pkt_parser: only FWD_LAT == 1 is supported");
    end

    localparam logic [1:0] POS_BODY   = 2'b00;
    localparam logic [1:0] POS_HEAD   = 2'b01;
    localparam logic [1:0] POS_TAIL   = 2'b10;
    localparam logic [1:0] POS_SINGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, FWD, CONF} state_e;

    state_e state_q, state_d;
    logic   fwd_beat;    // beat goes out on o_data next cycle
    logic   conf_write;  // beat becomes a config write next cycle
    logic   conf_done;   // config tail accepted
    logic   frame_err;   // stray body/tail, or head while inside a packet
    logic   is_conf;

    assign is_conf = (i_data[31:16] == CONF_ETHERTYPE);

    always_comb begin
        state_d    = state_q;
        fwd_beat   = 1'b0;
        conf_write = 1'b0;
        conf_done  = 1'b0;
        frame_err  = 1'b0;
        if (i_data_valid) begin
            case (i_data[133:132])
                POS_HEAD: begin
                    // A head inside a packet means the tail went missing. The
                    // truncated packet is abandoned and this head starts over.
                    frame_err = (state_q != IDLE);
                    if (is_conf) begin
                        state_d = CONF;
                    end else begin
                        state_d  = FWD;
                        fwd_beat = 1'b1;
                    end
                end
                POS_SINGLE: begin
                    // A single-beat config packet carries no write and is not
                    // counted.
                    frame_err = (state_q != IDLE);
                    state_d   = IDLE;
                    fwd_beat  = !is_conf;
                end
                POS_BODY, POS_TAIL: begin
                    case (state_q)
                        FWD:     fwd_beat   = 1'b1;
                        CONF:    conf_write = 1'b1;
                        default: frame_err  = 1'b1;  // stray beat, dropped
                    endcase
                    if (i_data[133:132] == POS_TAIL) begin
                        conf_done = (state_q == CONF);
                        state_d   = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_conf_valid <= 1'b0;
            o_conf_addr  <= '0;
            o_conf_data  <= '0;
        end else begin
            state_q      <= state_d;
            o_data_valid <= fwd_beat;
            o_conf_valid <= conf_write;
            if (fwd_beat) begin
                o_data <= i_data;
            end
            if (conf_write) begin
                o_conf_addr <= i_data[47:16];
                o_conf_data <= i_data[79:48];
            end
        end
    end

`ifdef CONF_PKT_STATS_EN
    logic [15:0] cnt_conf_q;
    logic [15:0] cnt_err_q;

    // The two counters are independent, so both may step in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_conf_q <= '0;
            cnt_err_q  <= '0;
        end else begin
            if (conf_done && (cnt_conf_q != 16'hFFFF)) begin
                cnt_conf_q <= cnt_conf_q + 16'd1;
            end
            if (frame_err && (cnt_err_q != 16'hFFFF)) begin
                cnt_err_q <= cnt_err_q + 16'd1;
            end
        end
    end

    assign o_cnt_conf_pkt = cnt_conf_q;
    assign o_cnt_err      = cnt_err_q;
`else
    logic unused_stats;
    assign unused_stats   = conf_done ^ frame_err;
    assign o_cnt_conf_pkt = '0;
    assign o_cnt_err      = '0;
`endif

endmodule

// File: tb/tb_conf_pkt_parser.sv
// Scoreboard bench for conf_pkt_parser. The stimulus tasks push the expected
// beat or write, together with the cycle in which it must appear. The monitor
// pops an entry and compares it whenever the DUT raises a strobe.

module tb_conf_pkt_parser;

    logic         clk;
    logic         rst;
    logic         i_data_valid;
    logic [133:0] i_data;
    logic         o_data_valid;
    logic [133:0] o_data;
    logic         o_conf_valid;
    logic [31:0]  o_conf_addr;
    logic [31:0]  o_conf_data;
    logic [15:0]  o_cnt_conf_pkt;
    logic [15:0]  o_cnt_err;

`ifdef CONF_PKT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    conf_pkt_parser dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_data_valid   (i_data_valid),
        .i_data         (i_data),
        .o_data_valid   (o_data_valid),
        .o_data         (o_data),
        .o_conf_valid   (o_conf_valid),
        .o_conf_addr    (o_conf_addr),
        .o_conf_data    (o_conf_data),
        .o_cnt_conf_pkt (o_cnt_conf_pkt),
        .o_cnt_err      (o_cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [133:0] d;
        int unsigned  c;
    } fwd_exp_t;
    typedef struct {
        logic [63:0]  aw;  // {addr, data}
        int unsigned  c;
    } wr_exp_t;

    fwd_exp_t fwd_q[$];
    wr_exp_t  wr_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample well away from the rising edge.
    always @(negedge clk) begin
        if (o_data_valid) begin
            if (fwd_q.size() == 0) begin
                chk("fwd_unexpected", o_data, '0);
                checks++;
                errors++;
                $display("FAIL fwd_unexpected: beat %h with no expected beat queued", o_data);
            end else begin
                fwd_exp_t e;
                e = fwd_q.pop_front();
                chk("fwd_data", o_data, e.d);
                chk("fwd_cycle", 134'(cyc), 134'(e.c));
            end
        end
        if (o_conf_valid) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: write addr %h data %h with none queued",
                         o_conf_addr, o_conf_data);
            end else begin
                wr_exp_t w;
                w = wr_q.pop_front();
                chk("wr_addr_data", 134'({o_conf_addr, o_conf_data}), 134'(w.aw));
                chk("wr_cycle", 134'(cyc), 134'(w.c));
            end
        end
    end

    function automatic logic [133:0] mk(input logic [1:0] pos, input logic [127:0] pl);
        return {pos, 4'hF, pl};
    endfunction

    function automatic logic [133:0] cfg(input logic [1:0] pos, input logic [31:0] addr,
                                         input logic [31:0] data);
        return {pos, 4'hA, 48'h0, data, addr, 16'h0};
    endfunction

    function automatic logic [133:0] head(input logic [1:0] pos, input logic [15:0] et);
        return {pos, 4'h0, 96'h0, et, 16'h0};
    endfunction

    // Beat that must be forwarded one cycle later.
    task automatic send_fwd(input logic [133:0] d);
        fwd_exp_t e;
        e.d = d;
        e.c = cyc + 1;
        fwd_q.push_back(e);
        i_data_valid = 1'b1;
        i_data       = d;
        @(posedge clk); #1;
        i_data_valid = 1'b0;
    endtask

    // Beat that must produce exactly this write one cycle later.
    task automatic send_wr(input logic [133:0] d, input logic [31:0] a, input logic [31:0] wd);
        wr_exp_t w;
        w.aw = {a, wd};
        w.c  = cyc + 1;
        wr_q.push_back(w);
        i_data_valid = 1'b1;
        i_data       = d;
        @(posedge clk); #1;
        i_data_valid = 1'b0;
    endtask

    // Beat that must produce no output at all.
    task automatic send_drop(input logic [133:0] d);
        i_data_valid = 1'b1;
        i_data       = d;
        @(posedge clk); #1;
        i_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int conf_n, input int err_n);
        chk({tag, "_cnt_conf"}, 134'(o_cnt_conf_pkt), STATS ? 134'(conf_n) : 134'(0));
        chk({tag, "_cnt_err"}, 134'(o_cnt_err), STATS ? 134'(err_n) : 134'(0));
    endtask

    // One reset cycle. A beat is presented meanwhile and must be discarded.
    task automatic do_reset(input logic [133:0] junk);
        rst          = 1'b1;
        i_data_valid = 1'b1;
        i_data       = junk;
        @(posedge clk); #1;
        rst          = 1'b0;
        i_data_valid = 1'b0;
        chk("rst_data_valid", 134'(o_data_valid), 134'(0));
        chk("rst_conf_valid", 134'(o_conf_valid), 134'(0));
        chk("rst_data", o_data, '0);
        chk("rst_conf_addr", 134'(o_conf_addr), 134'(0));
        chk("rst_conf_data", 134'(o_conf_data), 134'(0));
        chk("rst_cnt_conf", 134'(o_cnt_conf_pkt), 134'(0));
        chk("rst_cnt_err", 134'(o_cnt_err), 134'(0));
    endtask

    initial begin
        rst          = 1'b1;
        i_data_valid = 1'b0;
        i_data       = '0;
        idle(2);
        do_reset(mk(2'b01, 128'h1234));

        // Config packet: type offset
        send_drop(head(2'b01, 16'h9006));
        send_wr(cfg(2'b00, 32'h0, 32'h1), 32'h0000_0000, 32'h0000_0001);
        send_wr(cfg(2'b10, 32'h1, 32'h3), 32'h0000_0001, 32'h0000_0003);
        idle(2);
        chk_cnt("type_off", 1, 0);

        // Key-offset burst
        send_drop(head(2'b01, 16'h9006));
        for (int k = 1; k <= 8; k++) begin
            send_wr(cfg(2'b00, 32'h0001_0200 + 32'(k - 1), 32'(k)),
                    32'h0001_0200 + 32'(k - 1), 32'(k));
        end
        send_wr(cfg(2'b10, 32'h0001_0209, 32'h9), 32'h0001_0209, 32'h0000_0009);
        idle(2);
        chk_cnt("burst", 2, 0);

        // Normal packet, back to back
        send_fwd(head(2'b01, 16'h0800));
        send_fwd(mk(2'b00, 128'd1));
        send_fwd(mk(2'b00, 128'd2));
        send_fwd(mk(2'b00, 128'd3));
        send_fwd(mk(2'b10, 128'd4));
        idle(2);

        // Normal packet with idle gaps, which are neither added nor removed
        send_fwd(head(2'b01, 16'h86DD));
        idle(2);
        send_fwd(mk(2'b00, 128'hDEAD_BEEF));
        idle(1);
        send_fwd(mk(2'b10, 128'hCAFE));
        idle(2);
        chk_cnt("normal", 2, 0);

        // Framing errors
        send_drop(mk(2'b10, 128'h77));
        send_fwd(head(2'b01, 16'h0800));
        send_fwd(mk(2'b00, 128'h55));
        send_drop(head(2'b01, 16'h9006));
        send_wr(cfg(2'b00, 32'hAB00_0102, 32'h1111_2222), 32'hAB00_0102, 32'h1111_2222);
        send_wr(cfg(2'b10, 32'hAB00_0103, 32'h3333_4444), 32'hAB00_0103, 32'h3333_4444);
        idle(2);
        chk_cnt("framing", 3, 2);

        // Single-beat packets: the normal one is forwarded, the config one vanishes
        send_fwd(head(2'b11, 16'h0800));
        send_drop(head(2'b11, 16'h9006));
        idle(2);
        chk_cnt("single", 3, 2);

        // Reset mid-packet: the body and tail that follow are strays
        send_drop(head(2'b01, 16'h9006));
        send_wr(cfg(2'b00, 32'h10, 32'h20), 32'h0000_0010, 32'h0000_0020);
        do_reset(cfg(2'b00, 32'h11, 32'h21));
        send_drop(cfg(2'b00, 32'h12, 32'h22));
        send_drop(cfg(2'b10, 32'h13, 32'h23));
        idle(2);
        chk_cnt("rst_mid", 0, 2);

        idle(3);
        chk("fwd_queue_empty", 134'(fwd_q.size()), 134'(0));
        chk("wr_queue_empty", 134'(wr_q.size()), 134'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (checks %0d)", checks);
        $fatal(1);
    end

endmodule
